axi_ram_slave: RTL
==================

AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

Interface
REQ-001 Parameter MEM_AW, default 10, log2 of memory depth in 32-bit words.
REQ-002 Parameter ID_W, default 4, AXI ID width.
REQ-003 aclk  in  1  sole clock; all state changes on rising edge.
REQ-004 aresetn  in  1  reset, asynchronous, active-low.
REQ-005 arid  in  ID_W  read ID.
REQ-006 araddr  in  32  read start byte address.
REQ-007 arlen  in  4  read beats minus one (AXI3).
REQ-008 arburst  in  2  read burst type.
REQ-009 arvalid  in  1  read address valid.
REQ-010 arready  out  1  read address accepted.
REQ-011 rid  out  ID_W  read response ID.
REQ-012 rdata  out  32  read data.
REQ-013 rresp  out  2  read response, always 2'b00.
REQ-014 rlast  out  1  final read beat.
REQ-015 rvalid  out  1  read data valid.
REQ-016 rready  in  1  master accepts read beat.
REQ-017 awid  in  ID_W  write ID.
REQ-018 awaddr  in  32  write start byte address.
REQ-019 awlen  in  4  write beats minus one.
REQ-020 awburst  in  2  write burst type.
REQ-021 awvalid  in  1  write address valid.
REQ-022 awready  out  1  write address accepted.
REQ-023 wdata  in  32  write data.
REQ-024 wstrb  in  4  byte enables, bit i -> wdata[8i+7:8i].
REQ-025 wlast  in  1  master's last-beat marker.
REQ-026 wvalid  in  1  write data valid.
REQ-027 wready  out  1  write beat accepted.
REQ-028 bid  out  ID_W  write response ID.
REQ-029 bresp  out  2  write response.
REQ-030 bvalid  out  1  write response valid.
REQ-031 bready  in  1  master accepts response.
REQ-032 No size/lock/cache/prot/wid ports; all beats full-word, narrowing only via wstrb.

Function
REQ-033 Storage SHALL be a 2^MEM_AW x 32 register array; word index = addr[MEM_AW+1:2], upper bits ignored (aliasing).
REQ-034 FSM states IDLE, RD, WR, WRESP; exactly one transaction in flight.
REQ-035 In IDLE, arready/awready SHALL be combinational grants: only one asserted per cycle, only to a requester with valid high.
REQ-036 Arbitration round-robin: when both valid, grant the type not granted last; last-grant flag resets to "write", so read wins first conflict after reset.
REQ-037 AR handshake at cycle N -> RD; rvalid=1, rid=arid, rdata=mem[index] at N+1.
REQ-038 rvalid, rdata, rlast SHALL hold stable while rready=0; on rvalid&rready next beat presented next cycle (1 beat/cycle sustainable).
REQ-039 Beat counter runs 0..len; rlast=1 exactly on beat len; handshake of that beat -> IDLE, rvalid=0 next cycle.
REQ-040 Address step: burst 2'b00 (FIXED) holds index; 2'b01, 2'b10, 2'b11 increment index by 1, wrapping modulo 2^MEM_AW.
REQ-041 AW handshake -> WR; wready=1 throughout WR; each wvalid&wready beat writes only strobed bytes to mem[index].
REQ-042 Burst end governed by counter, not wlast; beat len accepted -> WRESP, wready=0.
REQ-043 bresp=2'b10 (SLVERR) if wlast differed from (counter==len) on any beat, else 2'b00; data written regardless.
REQ-044 WRESP: bvalid=1, bid=awid, held until bready; handshake -> IDLE.
REQ-045 Read in RD sees all bytes of prior completed write bursts (no read-during-write hazard).

Reset
REQ-046 aresetn low SHALL immediately force IDLE; arready, awready, wready, rvalid, rlast, bvalid = 0; rid, bid, rdata, rresp, bresp = 0.
REQ-047 Reset mid-burst abandons transaction; bytes already written persist; memory array not reset.

Verification
REQ-048 Write awaddr=0x10, awlen=3, INCR, data 0xA0..0xA3, wstrb=F, wlast on beat 3 -> bresp=00; read araddr=0x10 arlen=3 -> 0xA0..0xA3, rlast only on 4th beat.
REQ-049 mem[0]=0x11223344, write wstrb=4'b0101 data 0xAABBCCDD -> read returns 0x11BB33DD.
REQ-050 arvalid and awvalid both high from first post-reset cycle -> read granted first, write next IDLE; repeat -> alternates.
REQ-051 FIXED read arlen=2 at 0x8 with rready toggling 1-0-1-0 -> same word three times, rdata stable during stalls.
REQ-052 INCR write at last word index, awlen=1 -> second beat lands in word 0; wlast on beat 0 -> bresp=2'b10.
REQ-053 aresetn dropped in RD mid-burst -> rvalid=0 same cycle; after release, new read completes normally.

Source files
------------

// File: rtl/axi_ram_slave.sv
// rtl/axi_ram_slave.sv - single-outstanding AXI3 slave backed by a 2^MEM_AW x 32 register array.
module axi_ram_slave #(
  parameter int MEM_AW = 10,
  parameter int ID_W   = 4
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic [ID_W-1:0] arid,
  input  logic [31:0]     araddr,
  input  logic [3:0]      arlen,
  input  logic [1:0]      arburst,
  input  logic            arvalid,
  output logic            arready,
  output logic [ID_W-1:0] rid,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic            rlast,
  output logic            rvalid,
  input  logic            rready,
  input  logic [ID_W-1:0] awid,
  input  logic [31:0]     awaddr,
  input  logic [3:0]      awlen,
  input  logic [1:0]      awburst,
  input  logic            awvalid,
  output logic            awready,
  input  logic [31:0]     wdata,
  input  logic [3:0]      wstrb,
  input  logic            wlast,
  input  logic            wvalid,
  output logic            wready,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  output logic            bvalid,
  input  logic            bready
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_WRESP} state_t;

  state_t            state_q, state_d;
  logic              last_rd_q, last_rd_d;
  logic [MEM_AW-1:0] idx_q, idx_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        len_q, len_d;
  logic              fixed_q, fixed_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              slverr_q, slverr_d;

  logic [31:0]       mem [0:(1<<MEM_AW)-1];
  logic              mem_we;
  logic              at_last;
  logic [MEM_AW-1:0] idx_step;

  // Address bits outside the word index alias and are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{araddr[31:MEM_AW+2], araddr[1:0],
                              awaddr[31:MEM_AW+2], awaddr[1:0]};

  assign at_last  = (cnt_q == len_q);
  assign idx_step = fixed_q ? idx_q : idx_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    last_rd_d = last_rd_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    fixed_d   = fixed_q;
    id_d      = id_q;
    slverr_d  = slverr_q;
    arready   = 1'b0;
    awready   = 1'b0;
    mem_we    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Round-robin: on a conflict, the type not granted last wins.
        if (arvalid && (!awvalid || !last_rd_q)) begin
          arready   = 1'b1;
          last_rd_d = 1'b1;
          idx_d     = araddr[MEM_AW+1:2];
          cnt_d     = 4'd0;
          len_d     = arlen;
          fixed_d   = (arburst == 2'b00);
          id_d      = arid;
          state_d   = S_RD;
        end else if (awvalid) begin
          awready   = 1'b1;
          last_rd_d = 1'b0;
          idx_d     = awaddr[MEM_AW+1:2];
          cnt_d     = 4'd0;
          len_d     = awlen;
          fixed_d   = (awburst == 2'b00);
          id_d      = awid;
          slverr_d  = 1'b0;
          state_d   = S_WR;
        end
      end
      S_RD: begin
        if (rready) begin
          if (at_last) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
            idx_d = idx_step;
          end
        end
      end
      S_WR: begin
        if (wvalid) begin
          mem_we = 1'b1;
          if (wlast != at_last) slverr_d = 1'b1;
          if (at_last) begin
            state_d = S_WRESP;
          end else begin
            cnt_d = cnt_q + 4'd1;
            idx_d = idx_step;
          end
        end
      end
      S_WRESP: begin
        if (bready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      last_rd_q <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= 4'd0;
      len_q     <= 4'd0;
      fixed_q   <= 1'b0;
      id_q      <= '0;
      slverr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_rd_q <= last_rd_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      fixed_q   <= fixed_d;
      id_q      <= id_d;
      slverr_q  <= slverr_d;
    end
  end

  // Storage is deliberately not reset so data survives an aborted burst.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[idx_q][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rvalid = (state_q == S_RD);
  assign rlast  = rvalid && at_last;
  assign rdata  = rvalid ? mem[idx_q] : 32'd0;
  assign rid    = rvalid ? id_q : '0;
  assign rresp  = 2'b00;
  assign wready = (state_q == S_WR);
  assign bvalid = (state_q == S_WRESP);
  assign bid    = bvalid ? id_q : '0;
  assign bresp  = (bvalid && slverr_q) ? 2'b10 : 2'b00;

endmodule
